// File: rtl/planta_engarrafamento.sv
// planta_engarrafamento
// Behavioural plant model of the bottling line. It sits on the far side of the
// controller's actuator/sensor interface. It consumes the actuator commands and
// returns the sensor feedback that the production FSM reads. It also counts
// finished bottles and latches a fault on any illegal actuator sequence.
//
// Ports:
//   clk           system clock (the divided clock used by the FSMs)
//   reset         asynchronous, active-low reset
//   M             motor command, 1 = belt moving
//   EV            filling valve command, 1 = open
//   VE            sealing command, 1 = sealing active
//   PG            bottle present at station
//   CH            bottle full
//   RO            cork fitted (bottle sealed)
//   fault         sticky illegal-sequence flag
//   bottles_done  completed-bottle count, wraps 255 -> 0
//   state         current state code, for debug/monitoring
//
// Every output is a flop, or a direct copy of one. No input reaches an output
// without passing through a register first.
module planta_engarrafamento #(
  parameter int TRANSPORT_CYCLES = 8,
  parameter int FILL_CYCLES      = 6,
  parameter int SEAL_CYCLES      = 4,
  parameter int CW               = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       M,
  input  logic       EV,
  input  logic       VE,
  output logic       PG,
  output logic       CH,
  output logic       RO,
  output logic       fault,
  output logic [7:0] bottles_done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    TRANSPORTE  = 3'd0,
    POSICIONADA = 3'd1,
    CHEIA       = 3'd2,
    VEDADA      = 3'd3,
    FALHA       = 3'd4
  } state_t;

  // Last count value of each phase. The phase completes on the edge that
  // samples the actuator while cnt already holds this value.
  localparam logic [CW-1:0] T_LAST = CW'(TRANSPORT_CYCLES - 1);
  localparam logic [CW-1:0] F_LAST = CW'(FILL_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SEAL_CYCLES - 1);

  state_t        st;
  logic [CW-1:0] cnt;

  // PG, CH and RO are set or cleared only when a transition happens. That is
  // why FALHA holds them at whatever values they had in the state that faulted.
  // In every state the fault checks come before the progress checks, so a fault
  // wins over a completion in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st           <= TRANSPORTE;
      cnt          <= '0;
      bottles_done <= '0;
      fault        <= 1'b0;
      PG           <= 1'b0;
      CH           <= 1'b0;
      RO           <= 1'b0;
    end else begin
      case (st)
        TRANSPORTE: begin
          if (EV || VE) begin
            st    <= FALHA;
            fault <= 1'b1;
          end else if (M) begin
            if (cnt == T_LAST) begin
              st  <= POSICIONADA;
              cnt <= '0;
              PG  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        POSICIONADA: begin
          if (M || VE) begin
            st    <= FALHA;
            fault <= 1'b1;
          end else if (EV) begin
            if (cnt == F_LAST) begin
              st  <= CHEIA;
              cnt <= '0;
              CH  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        CHEIA: begin
          if (EV || M) begin
            st    <= FALHA;
            fault <= 1'b1;
          end else if (VE) begin
            if (cnt == S_LAST) begin
              st  <= VEDADA;
              cnt <= '0;
              RO  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        VEDADA: begin
          // VE is allowed to stay high here. The controller may keep sealing
          // for a few extra cycles.
          if (EV) begin
            st    <= FALHA;
            fault <= 1'b1;
          end else if (M) begin
            st           <= TRANSPORTE;
            cnt          <= '0;
            bottles_done <= bottles_done + 8'd1;
            PG           <= 1'b0;
            CH           <= 1'b0;
            RO           <= 1'b0;
          end
        end

        FALHA: begin
          // Absorbing state. Only reset leaves it.
        end

        default: begin
          st    <= FALHA;
          fault <= 1'b1;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_planta_engarrafamento.sv
module tb_planta_engarrafamento;

  logic       clk;
  logic       reset;
  logic       M, EV, VE;
  logic       PG, CH, RO, fault;
  logic [7:0] bottles_done;
  logic [2:0] state;

  int errors;
  int checks;

  planta_engarrafamento dut (
    .clk          (clk),
    .reset        (reset),
    .M            (M),
    .EV           (EV),
    .VE           (VE),
    .PG           (PG),
    .CH           (CH),
    .RO           (RO),
    .fault        (fault),
    .bottles_done (bottles_done),
    .state        (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge, then settle 1 time unit past it.
  // Inputs are driven and outputs are sampled at that point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    M = 1'b0; EV = 1'b0; VE = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // driver tasks
  task automatic drive(input logic m, input logic ev, input logic ve, input int n);
    M = m; EV = ev; VE = ve;
    for (int i = 0; i < n; i++) step();
    M = 1'b0; EV = 1'b0; VE = 1'b0;
  endtask

  task automatic goto_pos();   drive(1'b1, 1'b0, 1'b0, 8); endtask
  task automatic goto_cheia(); goto_pos(); drive(1'b0, 1'b1, 1'b0, 6); endtask
  task automatic goto_vedada(); goto_cheia(); drive(1'b0, 1'b0, 1'b1, 4); endtask
  task automatic bottle_cycle(); goto_vedada(); drive(1'b1, 1'b0, 1'b0, 1); endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({PG, CH, RO, fault} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000", {PG, CH, RO, fault});
    end
    checks++;
    if (state !== 3'd0 || bottles_done !== 8'd0) begin
      errors++; $display("FAIL reset_state: got state=%0d bottles=%0d expected 0/0", state, bottles_done);
    end
    // PG must rise exactly on the 8th edge with M held high.
    M = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (PG !== (i == 7)) begin
        errors++; $display("FAIL transport_pg edge %0d: got %b expected %b", i + 1, PG, (i == 7));
      end
    end
    M = 1'b0;
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("FAIL transport_state: got %0d expected 1", state);
    end
    // Assert reset asynchronously, away from any clock edge.
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (PG !== 1'b0 || state !== 3'd0) begin
      errors++; $display("FAIL async_reset: got PG=%b state=%0d expected 0/0", PG, state);
    end
    step();
    reset = 1'b1;
  endtask

  task automatic test_transport_pause();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4);
    drive(1'b0, 1'b0, 1'b0, 3);
    M = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (PG !== (i == 3)) begin
        errors++; $display("FAIL paused_transport_pg edge %0d: got %b expected %b", i + 1, PG, (i == 3));
      end
    end
    M = 1'b0;
  endtask

  task automatic test_full_cycle();
    do_reset();
    goto_pos();
    EV = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (CH !== (i == 5)) begin
        errors++; $display("FAIL fill_ch edge %0d: got %b expected %b", i + 1, CH, (i == 5));
      end
    end
    EV = 1'b0;
    VE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (RO !== (i == 3)) begin
        errors++; $display("FAIL seal_ro edge %0d: got %b expected %b", i + 1, RO, (i == 3));
      end
    end
    checks++;
    if (state !== 3'd3 || {PG, CH} !== 2'b11) begin
      errors++; $display("FAIL vedada: got state=%0d PG/CH=%b expected 3/11", state, {PG, CH});
    end
    VE = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1);
    checks++;
    if ({PG, CH, RO, fault} !== 4'b0000 || state !== 3'd0 || bottles_done !== 8'd1) begin
      errors++; $display("FAIL cycle_end: got outs=%b state=%0d bottles=%0d expected 0000/0/1",
                         {PG, CH, RO, fault}, state, bottles_done);
    end
  endtask

  task automatic test_interrupted_fill();
    do_reset();
    goto_pos();
    drive(1'b0, 1'b1, 1'b0, 3);
    drive(1'b0, 1'b0, 1'b0, 5);
    checks++;
    if (CH !== 1'b0 || state !== 3'd1) begin
      errors++; $display("FAIL partial_fill: got CH=%b state=%0d expected 0/1", CH, state);
    end
    EV = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (CH !== (i == 2) || fault !== 1'b0) begin
        errors++; $display("FAIL resumed_fill edge %0d: got CH=%b fault=%b expected %b/0",
                           i + 1, CH, fault, (i == 2));
      end
    end
    EV = 1'b0;
  endtask

  task automatic test_illegal();
    // EV while in TRANSPORTE
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1);
    checks++;
    if (fault !== 1'b1 || state !== 3'd4) begin
      errors++; $display("FAIL ev_in_transporte: got fault=%b state=%0d expected 1/4", fault, state);
    end
    drive(1'b1, 1'b0, 1'b0, 10);
    drive(1'b0, 1'b1, 1'b1, 5);
    checks++;
    if (state !== 3'd4 || {PG, CH, RO} !== 3'b000 || bottles_done !== 8'd0) begin
      errors++; $display("FAIL falha_absorb_a: got state=%0d PCR=%b bottles=%0d expected 4/000/0",
                         state, {PG, CH, RO}, bottles_done);
    end
    // M while in POSICIONADA
    do_reset();
    goto_pos();
    drive(1'b1, 1'b0, 1'b0, 1);
    checks++;
    if (fault !== 1'b1 || PG !== 1'b1 || state !== 3'd4) begin
      errors++; $display("FAIL m_in_posicionada: got fault=%b PG=%b state=%0d expected 1/1/4", fault, PG, state);
    end
    drive(1'b0, 1'b1, 1'b0, 8);
    checks++;
    if ({PG, CH, RO, fault} !== 4'b1001) begin
      errors++; $display("FAIL falha_absorb_b: got %b expected 1001", {PG, CH, RO, fault});
    end
    // EV while in CHEIA
    do_reset();
    goto_cheia();
    drive(1'b0, 1'b1, 1'b0, 1);
    checks++;
    if ({PG, CH, RO, fault} !== 4'b1101 || state !== 3'd4) begin
      errors++; $display("FAIL ev_in_cheia: got %b state=%0d expected 1101/4", {PG, CH, RO, fault}, state);
    end
    drive(1'b0, 1'b0, 1'b1, 6);
    drive(1'b1, 1'b0, 1'b0, 2);
    checks++;
    if ({PG, CH, RO, fault} !== 4'b1101 || bottles_done !== 8'd0) begin
      errors++; $display("FAIL falha_absorb_c: got %b bottles=%0d expected 1101/0", {PG, CH, RO, fault}, bottles_done);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    goto_pos();
    drive(1'b0, 1'b1, 1'b0, 5);
    // fill would complete on this edge, but M=1 must win
    drive(1'b1, 1'b1, 1'b0, 1);
    checks++;
    if (state !== 3'd4 || CH !== 1'b0 || fault !== 1'b1) begin
      errors++; $display("FAIL fault_beats_fill: got state=%0d CH=%b fault=%b expected 4/0/1", state, CH, fault);
    end
    do_reset();
    goto_cheia();
    drive(1'b0, 1'b0, 1'b1, 6);
    checks++;
    if (state !== 3'd3 || fault !== 1'b0 || RO !== 1'b1) begin
      errors++; $display("FAIL ve_held: got state=%0d fault=%b RO=%b expected 3/0/1", state, fault, RO);
    end
    drive(1'b1, 1'b0, 1'b0, 1);
    checks++;
    if (bottles_done !== 8'd1 || state !== 3'd0) begin
      errors++; $display("FAIL ve_held_release: got bottles=%0d state=%0d expected 1/0", bottles_done, state);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q[$];
    logic [7:0] exp_cnt;
    do_reset();
    for (int i = 1; i <= 256; i++) exp_q.push_back(8'(i));
    while (exp_q.size() > 0) begin
      exp_cnt = exp_q.pop_front();
      bottle_cycle();
      checks++;
      if (bottles_done !== exp_cnt || fault !== 1'b0) begin
        errors++; $display("FAIL wrap_count: got bottles=%0d fault=%b expected %0d/0", bottles_done, fault, exp_cnt);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    M = 1'b0; EV = 1'b0; VE = 1'b0;
    test_reset();
    test_transport_pause();
    test_full_cycle();
    test_interrupted_fill();
    test_illegal();
    test_simultaneous();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
